// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg -- shared core defines.
//
// Holds the fetch FSM state encodings and the default reset PC, next to the
// immediate-select and major-opcode constants used by decode.
//
// Build option: FETCH_MISALIGN_TRAP_EN adds the FAULT state (misaligned
// redirect trap). Without it the FSM only has RESET and RUN.
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] INST_BYTES       = 32'd4;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_RUN   = 2'd1
`ifdef FETCH_MISALIGN_TRAP_EN
        , ST_FAULT = 2'd2
`endif
    } fetch_state_e;

    // Immediate formats selected by decode / immediate generation.
    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_sel_e;

    // Major opcodes (inst[6:0]).
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // Sequential successor of a fetch address (wraps modulo 2^32).
    function automatic logic [31:0] next_word(input logic [31:0] pc);
        return pc + INST_BYTES;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo -- instruction buffer holding {pc, instruction} pairs.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   push, push_data    write one entry (caller guarantees not full)
//   pop                remove the head entry (caller guarantees not empty)
//   flush              empty the buffer; wins over push and pop
//   count              number of valid entries
//   head               oldest entry, zero while empty
// -----------------------------------------------------------------------------
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] count,
    output logic [WIDTH-1:0]       head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [$clog2(DEPTH):0] CNT_ONE = 1;
    localparam logic [PTR_W-1:0]       PTR_ONE = 1;
    localparam logic [PTR_W-1:0]       PTR_MAX = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_MAX) ? '0 : p + PTR_ONE;
    endfunction

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; the head is masked to
    // zero while empty, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit -- instruction fetch front end with a small in-order buffer.
//
// Issues sequential word fetches, tracks in-flight requests with a credit
// count so the buffer can never overflow, discards responses that belong to
// fetches made before a redirect, and presents {inst, inst_pc} to decode.
//
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   imem_req_valid/addr/ready      fetch request channel
//   imem_rsp_valid/data            in-order response, no backpressure
//   redirect_valid/pc              taken branch/jump, one-cycle pulse
//   inst_valid/inst/inst_pc        buffered instruction to decode
//   inst_ready                     decode consumes the head
//   fetch_fault                    (FETCH_MISALIGN_TRAP_EN only) sticky trap
//                                  raised by a misaligned redirect target
//
// Build option: FETCH_MISALIGN_TRAP_EN. Without it, redirect_pc[1:0] is
// treated as 2'b00 and there is no fault state.
// -----------------------------------------------------------------------------
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        fetch_fault
`endif
);

    localparam int               CNT_W      = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] CNT_ONE    = 1;
    localparam logic [CNT_W:0]   CREDIT_CAP = (CNT_W + 1)'(DEPTH);

    fetch_state_e     state;
    fetch_state_e     state_next;
    logic [31:0]      fetch_pc;
    logic [31:0]      rsp_pc;       // pc of the next response that will be kept
    logic [31:0]      target_pc;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] in_flight_next;
    logic [63:0]      head;
    logic             accept;
    logic             rsp_stale;
    logic             redirect_take;
    logic             push;
    logic             pop;

    // Credits: in-flight requests plus buffered entries never exceed DEPTH.
    assign imem_req_valid = (state == ST_RUN) &&
                            (({1'b0, outstanding} + {1'b0, count}) < CREDIT_CAP);
    assign imem_req_addr  = fetch_pc;
    assign accept         = imem_req_valid && imem_req_ready;

    assign redirect_take  = redirect_valid && (state == ST_RUN);
    assign rsp_stale      = (drop_cnt != '0);

    // A response in the redirect cycle is discarded along with the buffer.
    assign push = imem_rsp_valid && !rsp_stale && !redirect_take && (state == ST_RUN);
    assign pop  = inst_valid && inst_ready && !redirect_take;

    // Requests still in flight after this edge; on a redirect all of them
    // belong to the abandoned path.
    assign in_flight_next = outstanding + CNT_W'(accept) - CNT_W'(imem_rsp_valid);

`ifdef FETCH_MISALIGN_TRAP_EN
    logic trap;
    assign target_pc = redirect_pc;
    assign trap      = redirect_take && (redirect_pc[1:0] != 2'b00);
`else
    assign target_pc = redirect_pc & ~32'h3;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_RESET;
        else        state <= state_next;
    end

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_RESET: state_next = ST_RUN;
`ifdef FETCH_MISALIGN_TRAP_EN
            ST_RUN:   if (trap) state_next = ST_FAULT;
`endif
            default:  state_next = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= in_flight_next;
            if (redirect_take) begin
                fetch_pc <= target_pc;
                rsp_pc   <= target_pc;
                drop_cnt <= in_flight_next;
            end else begin
                if (accept) fetch_pc <= next_word(fetch_pc);
                if (push)   rsp_pc   <= next_word(rsp_pc);
                if (imem_rsp_valid && rsp_stale) drop_cnt <= drop_cnt - CNT_ONE;
            end
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (!rst_n)    fetch_fault <= 1'b0;
        else if (trap) fetch_fault <= 1'b1;
    end
`endif

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({rsp_pc, imem_rsp_data}),
        .pop       (pop),
        .flush     (redirect_take),
        .count     (count),
        .head      (head)
    );

    assign inst_valid = (count != '0);
    assign inst_pc    = head[63:32];
    assign inst       = head[31:0];

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit -- self-checking bench for fetch_unit.
//
// An instruction-memory model answers accepted requests in order after a
// random latency with a data word derived from the address. The reference is
// the program-order view: after reset or a redirect to T, decode must see
// T, T+4, T+8, ... each carrying mem_word(pc), and the memory must see the
// same address sequence. Expected pcs sit in a scoreboard queue filled by the
// stimulus side and drained by a monitor on every consumed instruction.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fetch_fault;
`endif

    fetch_unit #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .fetch_fault    (fetch_fault)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_val);
        n_checks++;
        if (act !== exp_val) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp_val, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    // ---------------- instruction memory model ----------------
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_req_t;

    mem_req_t pend_q[$];
    int ready_mode = 0;   // 0: always ready, 1: random, 2: never ready
    int lat_max    = 0;   // extra response delay, cycles

    always @(posedge clk) begin
        #2;
        if (!rst_n) begin
            pend_q.delete();
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
            imem_req_ready = 1'b0;
        end else begin
            case (ready_mode)
                0:       imem_req_ready = 1'b1;
                1:       imem_req_ready = ($urandom_range(0, 3) != 0);
                default: imem_req_ready = 1'b0;
            endcase
            if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(pend_q[0].addr);
                void'(pend_q.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = '0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && imem_req_valid && imem_req_ready)
            pend_q.push_back('{addr: imem_req_addr,
                               due:  cyc + 1 + int'($urandom_range(0, lat_max))});
    end

    // ---------------- reference model / scoreboard ----------------
    logic [31:0] sb_q[$];
    logic [31:0] sb_next;
    logic [31:0] exp_req_pc;
    bit          faulted = 1'b0;
    int          acc_cnt = 0;
    int          pop_cnt = 0;
    int          total_pops = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr = '0;

    task automatic model_restart(input logic [31:0] pc);
        sb_q.delete();
        exp_req_pc = pc;
        sb_next    = pc;
        acc_cnt    = 0;
        pop_cnt    = 0;
        for (int i = 0; i < 4; i++) begin
            sb_q.push_back(sb_next);
            sb_next += 32'd4;
        end
    endtask

    // Monitor: decisions taken at the falling edge describe the next rising edge.
    always @(negedge clk) begin
        logic [31:0] exp_pc;
        if (rst_n) begin
            if (!redirect_valid) begin
                if (imem_req_valid && imem_req_ready) begin
                    check("req_addr", imem_req_addr, exp_req_pc);
                    exp_req_pc += 32'd4;
                    acc_cnt++;
                end
                if (inst_valid && inst_ready) begin
                    if (sb_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL inst_unexpected: got pc 0x%08h, expected no instruction (t=%0t)",
                                 inst_pc, $time);
                    end else begin
                        exp_pc = sb_q.pop_front();
                        check("inst_pc", inst_pc, exp_pc);
                        check("inst_data", inst, mem_word(exp_pc));
                    end
                    pop_cnt++;
                    total_pops++;
                    if (!faulted) begin
                        while (sb_q.size() < 4) begin
                            sb_q.push_back(sb_next);
                            sb_next += 32'd4;
                        end
                    end
                end
            end
            if (prev_stall && imem_req_valid) check("req_addr_hold", imem_req_addr, prev_addr);
            prev_stall = imem_req_valid && !imem_req_ready && !redirect_valid;
            prev_addr  = imem_req_addr;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("rst_req_addr", imem_req_addr, RESET_PC);
        check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_inst_pc", inst_pc, 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("rst_fetch_fault", {31'd0, fetch_fault}, 32'd0);
`endif
        faulted = 1'b0;
        model_restart(RESET_PC);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Called at drive time within a cycle; returns at drive time of the next.
    task automatic redirect_now(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
`ifdef FETCH_MISALIGN_TRAP_EN
        if (pc[1:0] != 2'b00) begin
            faulted = 1'b1;
            sb_q.delete();
        end else begin
            model_restart(pc);
        end
`else
        model_restart(pc & ~32'h3);
`endif
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at t=%0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- test sequence ----------------
    initial begin
        bit          found;
        logic [31:0] rnd_pc;

        // Streaming from reset: 0x0, 0x4, 0x8 requested and delivered in order.
        ready_mode = 0;
        lat_max    = 0;
        inst_ready = 1'b1;
        do_reset();
        tick(12);
        check("a_delivered", (pop_cnt >= 3) ? 32'd1 : 32'd0, 32'd1);

        // Decode stalls: buffer fills to DEPTH, requests stop, then drains 1/cycle.
        inst_ready = 1'b0;
        tick(8);
        @(negedge clk);
        check("b_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("b_inst_valid", {31'd0, inst_valid}, 32'd1);
        check("b_buffered", 32'(acc_cnt - pop_cnt), 32'(DEPTH));
        @(posedge clk);
        #1;
        inst_ready = 1'b1;
        @(negedge clk);
        check("b_pop0_valid", {31'd0, inst_valid}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("b_pop1_valid", {31'd0, inst_valid}, 32'd1);
        tick(4);

        // Memory not ready for 3 cycles: address held at reset PC.
        ready_mode = 2;
        do_reset();
        tick(1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("c_req_valid", {31'd0, imem_req_valid}, 32'd1);
            check("c_addr_hold", imem_req_addr, RESET_PC);
            @(posedge clk);
            #1;
        end
        ready_mode = 0;
        tick(8);
        check("c_progress", (pop_cnt >= 1) ? 32'd1 : 32'd0, 32'd1);

        // Redirect to 0x100 with two responses in flight.
        lat_max = 4;
        found   = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk);
            #3;
            if (pend_q.size() == 2 && !imem_rsp_valid) begin
                found = 1'b1;
                redirect_now(32'h0000_0100);
            end
        end
        check("d_two_outstanding_seen", {31'd0, found}, 32'd1);
        tick(30);
        check("d_progress", (pop_cnt >= 1) ? 32'd1 : 32'd0, 32'd1);

        // Redirect coinciding with a response and a request accept.
        lat_max = 0;
        tick(10);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk);
            #3;
            if (imem_req_valid && imem_req_ready && imem_rsp_valid) begin
                found = 1'b1;
                redirect_now(32'h0000_0100);
            end
        end
        check("e_collision_seen", {31'd0, found}, 32'd1);
        @(negedge clk);
        check("e_fetch_pc", imem_req_addr, 32'h0000_0100);
        tick(10);
        check("e_progress", (pop_cnt >= 1) ? 32'd1 : 32'd0, 32'd1);

        // Misaligned redirect target.
        tick(5);
        redirect_now(32'h0000_0102);
`ifdef FETCH_MISALIGN_TRAP_EN
        @(negedge clk);
        check("f_fetch_fault", {31'd0, fetch_fault}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("f_req_blocked", {31'd0, imem_req_valid}, 32'd0);
        end
        check("f_inst_empty", {31'd0, inst_valid}, 32'd0);
        do_reset();
        tick(10);
        check("f_restart", (pop_cnt >= 1) ? 32'd1 : 32'd0, 32'd1);
`else
        @(negedge clk);
        check("f_aligned_pc", imem_req_addr, 32'h0000_0100);
        tick(10);
        check("f_progress", (pop_cnt >= 1) ? 32'd1 : 32'd0, 32'd1);
`endif

        // Address wrap, then randomized traffic with redirects and a mid-run reset.
        redirect_now(32'hFFFF_FFF8);
        tick(12);
        check("g_wrap_progress", (pop_cnt >= 3) ? 32'd1 : 32'd0, 32'd1);
        ready_mode = 1;
        lat_max    = 3;
        for (int i = 0; i < 1500; i++) begin
            inst_ready = ($urandom_range(0, 3) != 0);
            if (i == 700) begin
                do_reset();
            end else if ($urandom_range(0, 29) == 0) begin
                rnd_pc      = $urandom;
                rnd_pc[1:0] = 2'b00;
                redirect_now(rnd_pc);
            end else begin
                tick(1);
            end
        end
        check("g_liveness", (total_pops >= 150) ? 32'd1 : 32'd0, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
